// File: rtl/tdo_shift_scheduler.sv
// Round-robin scheduler that shares one 32-bit TDO serializer between NUM_REQ data-register sources.
// Optional: define TDO_SHIFT_WATCHDOG_EN to add a 48-cycle SHIFT timeout reported as status 10.
module tdo_shift_scheduler #(
   parameter int NUM_REQ = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [32*NUM_REQ-1:0] req_data,
   input  logic                  abort,
   output logic [NUM_REQ-1:0]    grant,
   output logic                  busy,
   output logic                  complete,
   output logic [1:0]            complete_id,
   output logic [1:0]            complete_status,
   output logic                  tx_enable,
   output logic [31:0]           tx_data,
   input  logic                  tx_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } stateT;

   localparam logic [1:0] STATUS_OK      = 2'b00;
   localparam logic [1:0] STATUS_ABORT   = 2'b01;
   localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
   localparam logic [1:0] LAST_INIT      = 2'(NUM_REQ - 1);

   stateT                r_state;
   logic [NUM_REQ-1:0]   r_grant;
   logic                 r_busy;
   logic                 r_complete;
   logic [1:0]           r_completeId;
   logic [1:0]           r_completeStatus;
   logic                 r_txEnable;
   logic [31:0]          r_txData;
   logic [1:0]           r_last;

   stateT                w_stateNext;
   logic [NUM_REQ-1:0]   w_grantNext;
   logic                 w_busyNext;
   logic                 w_completeNext;
   logic [1:0]           w_idNext;
   logic [1:0]           w_statusNext;
   logic                 w_txEnableNext;
   logic [31:0]          w_txDataNext;
   logic [1:0]           w_lastNext;

   logic [2*NUM_REQ-1:0] w_reqRot;
   logic [64*NUM_REQ-1:0] w_dataRot;
   logic                 w_found;
   logic [1:0]           w_pickIdx;
   logic [31:0]          w_pickData;
   int                   w_scanSum;
   logic                 w_timeout;

`ifdef TDO_SHIFT_WATCHDOG_EN
   logic [5:0]           r_wdCount;

   // Counts SHIFT cycles; it sits at 47 during the 48th one, which is when the timeout fires.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wdCount <= '0;
      end else if (r_state == SHIFT) begin
         r_wdCount <= r_wdCount + 6'd1;
      end else begin
         r_wdCount <= '0;
      end
   end

   assign w_timeout = (r_wdCount == 6'd47);
`else
   assign w_timeout = 1'b0;
`endif

   // Rotate requests and words so that position 0 is requester last+1, then take the first set bit.
   always_comb begin
      w_reqRot   = {req, req} >> (int'(r_last) + 1);
      w_dataRot  = {req_data, req_data} >> (32 * (int'(r_last) + 1));
      w_found    = 1'b0;
      w_pickIdx  = '0;
      w_pickData = '0;
      w_scanSum  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && w_reqRot[0]) begin
            w_found   = 1'b1;
            w_scanSum = int'(r_last) + 1 + i;
            if (w_scanSum >= NUM_REQ) begin
               w_scanSum = w_scanSum - NUM_REQ;
            end
            w_pickIdx  = 2'(w_scanSum);
            w_pickData = w_dataRot[31:0];
         end
         w_reqRot  = w_reqRot >> 1;
         w_dataRot = w_dataRot >> 32;
      end
   end

   always_comb begin
      w_stateNext    = r_state;
      w_grantNext    = '0;
      w_busyNext     = r_busy;
      w_completeNext = 1'b0;
      w_idNext       = r_completeId;
      w_statusNext   = r_completeStatus;
      w_txEnableNext = r_txEnable;
      w_txDataNext   = r_txData;
      w_lastNext     = r_last;
      case (r_state)
         IDLE: begin
            if (!abort && w_found) begin
               w_stateNext    = SHIFT;
               w_grantNext    = NUM_REQ'(1) << w_pickIdx;
               w_busyNext     = 1'b1;
               w_txEnableNext = 1'b1;
               w_txDataNext   = w_pickData;
               w_lastNext     = w_pickIdx;
            end
         end
         SHIFT: begin
            // A finishing serializer outranks abort, which outranks the watchdog.
            if (tx_done || abort || w_timeout) begin
               w_stateNext    = GAP;
               w_busyNext     = 1'b0;
               w_txEnableNext = 1'b0;
               w_completeNext = 1'b1;
               w_idNext       = r_last;
               if (tx_done) begin
                  w_statusNext = STATUS_OK;
               end else if (abort) begin
                  w_statusNext = STATUS_ABORT;
               end else begin
                  w_statusNext = STATUS_TIMEOUT;
               end
            end
         end
         GAP: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= IDLE;
         r_grant          <= '0;
         r_busy           <= 1'b0;
         r_complete       <= 1'b0;
         r_completeId     <= '0;
         r_completeStatus <= '0;
         r_txEnable       <= 1'b0;
         r_txData         <= '0;
         r_last           <= LAST_INIT;
      end else begin
         r_state          <= w_stateNext;
         r_grant          <= w_grantNext;
         r_busy           <= w_busyNext;
         r_complete       <= w_completeNext;
         r_completeId     <= w_idNext;
         r_completeStatus <= w_statusNext;
         r_txEnable       <= w_txEnableNext;
         r_txData         <= w_txDataNext;
         r_last           <= w_lastNext;
      end
   end

   assign grant           = r_grant;
   assign busy            = r_busy;
   assign complete        = r_complete;
   assign complete_id     = r_completeId;
   assign complete_status = r_completeStatus;
   assign tx_enable       = r_txEnable;
   assign tx_data         = r_txData;

endmodule

// File: tb/tb_tdo_shift_scheduler.sv
// Directed self-checking bench for tdo_shift_scheduler (NUM_REQ=2); tx_done is driven by hand.
`timescale 1ns/1ps
module tb_tdo_shift_scheduler;

   localparam int NUM_REQ = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NUM_REQ-1:0]    req;
   logic [32*NUM_REQ-1:0] req_data;
   logic                  abort;
   logic [NUM_REQ-1:0]    grant;
   logic                  busy;
   logic                  complete;
   logic [1:0]            complete_id;
   logic [1:0]            complete_status;
   logic                  tx_enable;
   logic [31:0]           tx_data;
   logic                  tx_done;

   int testsRun    = 0;
   int testsFailed = 0;

   tdo_shift_scheduler #(.NUM_REQ(NUM_REQ)) dut (
      .clk             (clk),
      .reset           (reset),
      .req             (req),
      .req_data        (req_data),
      .abort           (abort),
      .grant           (grant),
      .busy            (busy),
      .complete        (complete),
      .complete_id     (complete_id),
      .complete_status (complete_status),
      .tx_enable       (tx_enable),
      .tx_data         (tx_data),
      .tx_done         (tx_done)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge, half a period from the active edge.
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] reqV, input logic abortV, input logic doneV);
      req     = reqV;
      abort   = abortV;
      tx_done = doneV;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_grant"},    32'(grant),           32'h0);
      checkOutput({tag, "_busy"},     32'(busy),            32'h0);
      checkOutput({tag, "_complete"}, 32'(complete),        32'h0);
      checkOutput({tag, "_id"},       32'(complete_id),     32'h0);
      checkOutput({tag, "_status"},   32'(complete_status), 32'h0);
      checkOutput({tag, "_txen"},     32'(tx_enable),       32'h0);
      checkOutput({tag, "_txdata"},   tx_data,              32'h0);
   endtask

   // From a grant cycle: done on the 34th enable cycle, complete next, IDLE after, then the regrant.
   task automatic finishAndRegrant(input string tag, input logic [1:0] expId,
                                   input logic [NUM_REQ-1:0] expGrant, input logic [31:0] expData);
      tick(33);
      applyStimulus(req, 1'b0, 1'b1);
      tick(1);
      applyStimulus(req, 1'b0, 1'b0);
      checkOutput({tag, "_complete"}, 32'(complete),    32'h1);
      checkOutput({tag, "_id"},       32'(complete_id), 32'(expId));
      tick(1);
      checkOutput({tag, "_gap_grant"}, 32'(grant), 32'h0);
      tick(1);
      checkOutput({tag, "_grant"}, 32'(grant), 32'(expGrant));
      checkOutput({tag, "_data"},  tx_data,    expData);
   endtask

   initial begin
      reset    = 1'b1;
      req_data = {32'h12345678, 32'hDEADBEEF};
      applyStimulus(2'b00, 1'b0, 1'b0);
      tick(2);
      checkAllZero("reset");
      reset = 1'b0;

      // Single word from requester 0.
      applyStimulus(2'b01, 1'b0, 1'b0);
      tick(1);
      checkOutput("single_grant", 32'(grant),     32'h1);
      checkOutput("single_txen",  32'(tx_enable), 32'h1);
      checkOutput("single_busy",  32'(busy),      32'h1);
      checkOutput("single_data",  tx_data,        32'hDEADBEEF);
      applyStimulus(2'b00, 1'b0, 1'b0);
      req_data[31:0] = 32'hCAFEF00D;
      tick(1);
      checkOutput("single_grant_pulse", 32'(grant), 32'h0);
      tick(31);
      checkOutput("single_data_stable", tx_data,       32'hDEADBEEF);
      checkOutput("single_no_early",    32'(complete), 32'h0);
      tick(1);
      checkOutput("single_txen_last", 32'(tx_enable), 32'h1);
      applyStimulus(2'b00, 1'b0, 1'b1);
      tick(1);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("single_complete", 32'(complete),        32'h1);
      checkOutput("single_id",       32'(complete_id),     32'h0);
      checkOutput("single_status",   32'(complete_status), 32'h0);
      checkOutput("single_txen_off", 32'(tx_enable),       32'h0);
      checkOutput("single_busy_off", 32'(busy),            32'h0);
      checkOutput("single_data_hold", tx_data,             32'hDEADBEEF);
      tick(1);
      checkOutput("single_complete_pulse", 32'(complete), 32'h0);
      req_data = {32'h12345678, 32'hDEADBEEF};

      // Abort ten cycles after the grant, then grants held off while abort stays high.
      applyStimulus(2'b01, 1'b0, 1'b0);
      tick(1);
      checkOutput("abort_grant", 32'(grant), 32'h1);
      applyStimulus(2'b00, 1'b0, 1'b0);
      tick(10);
      applyStimulus(2'b00, 1'b1, 1'b0);
      tick(1);
      checkOutput("abort_txen",     32'(tx_enable),       32'h0);
      checkOutput("abort_complete", 32'(complete),        32'h1);
      checkOutput("abort_status",   32'(complete_status), 32'h1);
      checkOutput("abort_id",       32'(complete_id),     32'h0);
      applyStimulus(2'b10, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick(1);
         checkOutput("abort_block_grant", 32'(grant), 32'h0);
         checkOutput("abort_block_busy",  32'(busy),  32'h0);
      end
      applyStimulus(2'b10, 1'b0, 1'b0);
      tick(1);
      checkOutput("abort_resume_grant", 32'(grant), 32'h2);
      checkOutput("abort_resume_data",  tx_data,    32'h12345678);
      applyStimulus(2'b00, 1'b0, 1'b0);

      // tx_done and abort together on the completing cycle.
      tick(33);
      applyStimulus(2'b00, 1'b1, 1'b1);
      tick(1);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("simul_complete", 32'(complete),        32'h1);
      checkOutput("simul_status",   32'(complete_status), 32'h0);
      checkOutput("simul_id",       32'(complete_id),     32'h1);
      tick(1);

      // Reset in SHIFT cycle 20 of a requester-0 word; priority must return to requester 0.
      applyStimulus(2'b01, 1'b0, 1'b0);
      tick(1);
      checkOutput("rst_pre_grant", 32'(grant), 32'h1);
      applyStimulus(2'b00, 1'b0, 1'b0);
      tick(19);
      checkOutput("rst_pre_txen", 32'(tx_enable), 32'h1);
      reset = 1'b1;
      tick(1);
      checkAllZero("rst_mid");
      tick(1);
      checkOutput("rst_no_complete", 32'(complete), 32'h0);
      reset = 1'b0;

      // Round-robin with both requests held: 01, 10, 01 at 36-cycle spacing.
      applyStimulus(2'b11, 1'b0, 1'b0);
      tick(1);
      checkOutput("rr_grant0", 32'(grant), 32'h1);
      checkOutput("rr_data0",  tx_data,    32'hDEADBEEF);
      finishAndRegrant("rr_1", 2'd0, 2'b10, 32'h12345678);
      finishAndRegrant("rr_2", 2'd1, 2'b01, 32'hDEADBEEF);
      applyStimulus(2'b00, 1'b0, 1'b0);

`ifdef TDO_SHIFT_WATCHDOG_EN
      tick(46);
      checkOutput("wd_cycle47_complete", 32'(complete),  32'h0);
      checkOutput("wd_cycle47_txen",     32'(tx_enable), 32'h1);
      tick(1);
      checkOutput("wd_cycle48_complete", 32'(complete), 32'h0);
      tick(1);
      checkOutput("wd_complete", 32'(complete),        32'h1);
      checkOutput("wd_status",   32'(complete_status), 32'h2);
      checkOutput("wd_id",       32'(complete_id),     32'h0);
      checkOutput("wd_txen",     32'(tx_enable),       32'h0);
      checkOutput("wd_busy",     32'(busy),            32'h0);
      tick(1);
      checkOutput("wd_idle_complete", 32'(complete), 32'h0);
`else
      for (int k = 0; k < 60; k++) begin
         tick(1);
         checkOutput("nowd_complete", 32'(complete),  32'h0);
         checkOutput("nowd_txen",     32'(tx_enable), 32'h1);
      end
      applyStimulus(2'b00, 1'b1, 1'b0);
      tick(1);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("nowd_abort_complete", 32'(complete),        32'h1);
      checkOutput("nowd_abort_status",   32'(complete_status), 32'h1);
      tick(1);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
